// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Defines a fetch entry as a {pc, instr} pair.
package fetch_queue_pkg;
    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/fetch_fifo.sv
// Purpose: synchronous FIFO of fetch entries, with a flush input and zeroed storage on reset.
// Latency: a pushed entry becomes the head on the cycle after the push.
// Backpressure: a push while full is dropped and a pop while empty is ignored; the caller budgets credits.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_dat,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// Purpose: sequential-PC fetch front end feeding decode; redirect flushes queued and in-flight fetches. Optional macro: FETCH_BYPASS_EN.
// Latency: issue to id_valid is 2 cycles, or 1 cycle through the empty-queue bypass when FETCH_BYPASS_EN is defined.
// Backpressure: id_valid/id_ready handshake; fetch stalls once queued entries plus the in-flight request would reach DEPTH.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] fetch_pc
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int UW = CW + 1;

    logic [XLEN-1:0] req_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    resp;
    logic [UW-1:0]   used;
    logic            resp_vld;
    logic            push;
    logic            pop;

    // The in-flight request already owns a slot, so the FIFO can never overflow.
    assign used      = UW'(count) + UW'(inflight);
    assign imem_en   = !rst && !redirect && (used < UW'(DEPTH));
    assign imem_addr = fetch_pc;
    assign resp_vld  = inflight && !redirect;
    assign resp      = '{pc: req_pc, instr: imem_rdata};

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass   = resp_vld && (count == '0);
    assign id_valid = bypass || ((count != '0) && !redirect);
    assign id_instr = bypass ? imem_rdata : head.instr;
    assign id_pc    = bypass ? req_pc : head.pc;
    assign push     = resp_vld && !(bypass && id_ready);
    assign pop      = (count != '0) && !redirect && id_ready;
`else
    assign id_valid = (count != '0) && !redirect;
    assign id_instr = head.instr;
    assign id_pc    = head.pc;
    assign push     = resp_vld;
    assign pop      = id_valid && id_ready;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~32'h3;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .push     (push),
        .push_dat (resp),
        .pop      (pop),
        .count    (count),
        .head     (head)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// Table-driven bench for fetch_queue with an in-order scoreboard of expected PCs.
module tb_fetch_queue;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef FETCH_BYPASS_EN
    localparam int L = 1;
`else
    localparam int L = 2;
`endif
    localparam logic [3:0] C_EN = 4'd1, C_AD = 4'd2, C_VD = 4'd4, C_PC = 4'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] fetch_pc;

    logic        w_en;
    logic [31:0] w_addr;
    logic [31:0] w_rdata = '0;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_fpc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .fetch_pc(fetch_pc)
    );

    fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .imem_en(w_en), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .redirect(1'b0), .redirect_pc(32'h0),
        .id_valid(w_valid), .id_ready(1'b1), .id_instr(w_instr),
        .id_pc(w_pc), .fetch_pc(w_fpc)
    );

    // 1-cycle BRAM models
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr ^ KEY;
        if (w_en)    w_rdata    <= w_addr ^ KEY;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: independent model of the fetch PC and the in-order delivery stream.
    logic [31:0] sb[$];
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_head;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_pc = 32'h0;
        end else if (redirect) begin
            chk("redir_en", {31'b0, imem_en}, 32'd0);
            chk("redir_vld", {31'b0, id_valid}, 32'd0);
            sb.delete();
            exp_pc = redirect_pc & ~32'h3;
        end else begin
            if (id_valid && id_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow actual_pc=%h required=none", id_pc);
                end else begin
                    exp_head = sb.pop_front();
                    chk("sb_pc", id_pc, exp_head);
                    chk("sb_instr", id_instr, exp_head ^ KEY);
                end
            end
            if (imem_en) begin
                chk("sb_addr", imem_addr, exp_pc);
                sb.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    // Capture the first three deliveries of the wrap-around instance.
    logic [31:0] wpcs[3];
    logic [31:0] winstr[3];
    int widx = 0;
    always @(negedge clk) begin
        if (rst) widx = 0;
        else if (w_valid && widx < 3) begin
            wpcs[widx]   = w_pc;
            winstr[widx] = w_instr;
            widx++;
        end
    end

    typedef struct {
        logic        rst, rdy, redir;
        logic [31:0] rpc;
        logic [3:0]  chk;
        logic        en;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc,
                       input logic [3:0] c, input logic en, input logic [31:0] addr,
                       input logic vld, input logic [31:0] pc);
        vec_t v;
        v = '{rst: r, rdy: rdy, redir: rd, rpc: rpc, chk: c, en: en, addr: addr, vld: vld, pc: pc};
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        vec_t v;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(posedge clk);
            #1;
            rst = v.rst; id_ready = v.rdy; redirect = v.redir; redirect_pc = v.rpc;
            @(negedge clk);
            if (v.chk[0]) chk($sformatf("%s[%0d].en", tag, i), {31'b0, imem_en}, {31'b0, v.en});
            if (v.chk[1]) chk($sformatf("%s[%0d].addr", tag, i), imem_addr, v.addr);
            if (v.chk[2]) chk($sformatf("%s[%0d].vld", tag, i), {31'b0, id_valid}, {31'b0, v.vld});
            if (v.chk[3]) chk($sformatf("%s[%0d].pc", tag, i), id_pc, v.pc);
        end
        vecs.delete();
    endtask

    localparam logic [3:0] C_ALL = 4'hF;

    initial begin
        // Phase A: reset, then streaming with id_ready held high.
        add(1, 0, 0, 0, C_ALL, 0, 32'h0, 0, 32'h0);
        add(1, 0, 0, 0, C_ALL, 0, 32'h0, 0, 32'h0);
        for (int k = 0; k < 8; k++)
            add(0, 1, 0, 0, (k >= L) ? C_ALL : (C_EN | C_AD | C_VD), 1, 32'(4 * k),
                k >= L, (k >= L) ? 32'(4 * (k - L)) : 32'h0);
        @(negedge clk);
        chk("rst_fetch_pc", fetch_pc, 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        run_vecs("stream");
        chk("steady_count", 32'(u_dut.u_fifo.count), (L == 1) ? 32'd0 : 32'd1);
        chk("wrap_n", 32'(widx), 32'd3);
        chk("wrap_pc0", wpcs[0], 32'hFFFF_FFF8);
        chk("wrap_pc1", wpcs[1], 32'hFFFF_FFFC);
        chk("wrap_pc2", wpcs[2], 32'h0000_0000);
        chk("wrap_in2", winstr[2], 32'h0000_0000 ^ KEY);

        // Phase B: decode stalled for 10 cycles, then drains in order.
        add(1, 0, 0, 0, C_EN | C_VD, 0, 32'h0, 0, 32'h0);
        for (int k = 0; k < 10; k++)
            add(0, 0, 0, 0, (k >= L) ? C_ALL : (C_EN | C_AD | C_VD), k < 4,
                (k < 4) ? 32'(4 * k) : 32'h10, k >= L, 32'h0);
        add(0, 1, 0, 0, C_ALL, 0, 32'h10, 1, 32'h0);
        add(0, 1, 0, 0, C_ALL, 1, 32'h10, 1, 32'h4);
        add(0, 1, 0, 0, C_ALL, 1, 32'h14, 1, 32'h8);
        add(0, 1, 0, 0, C_ALL, 1, 32'h18, 1, 32'hC);
        add(0, 1, 0, 0, C_VD | C_PC, 0, 32'h0, 1, 32'h10);
        run_vecs("stall");

        // Phase C: redirect with a nearly full queue and a request in flight, then back-to-back redirects.
        add(1, 0, 0, 0, C_EN | C_VD, 0, 32'h0, 0, 32'h0);
        for (int k = 0; k < 4; k++)
            add(0, 0, 0, 0, C_EN | C_AD, 1, 32'(4 * k), 0, 32'h0);
        add(0, 1, 1, 32'h0000_0103, C_EN | C_VD, 0, 32'h0, 0, 32'h0);
        add(0, 1, 0, 0, C_EN | C_AD | C_VD, 1, 32'h100, 0, 32'h0);
        add(0, 1, 0, 0, (L == 1) ? C_ALL : (C_EN | C_AD | C_VD), 1, 32'h104, L == 1, 32'h100);
        add(0, 1, 0, 0, C_ALL, 1, 32'h108, 1, (L == 1) ? 32'h104 : 32'h100);
        add(0, 1, 1, 32'h0000_0200, C_EN | C_VD, 0, 32'h0, 0, 32'h0);
        add(0, 1, 1, 32'h0000_0305, C_EN | C_VD, 0, 32'h0, 0, 32'h0);
        add(0, 1, 0, 0, C_EN | C_AD | C_VD, 1, 32'h304, 0, 32'h0);
        add(0, 1, 0, 0, (L == 1) ? C_ALL : (C_EN | C_AD | C_VD), 1, 32'h308, L == 1, 32'h304);
        add(0, 1, 0, 0, C_VD | C_PC, 0, 32'h0, 1, (L == 1) ? 32'h308 : 32'h304);
        // Phase D: one-cycle reset mid-stream with a response in flight.
        add(1, 1, 0, 0, C_ALL, 0, 32'h0, 0, 32'h0);
        add(0, 1, 0, 0, C_EN | C_AD | C_VD, 1, 32'h0, 0, 32'h0);
        add(0, 1, 0, 0, (L == 1) ? C_ALL : (C_EN | C_AD | C_VD), 1, 32'h4, L == 1, 32'h0);
        add(0, 1, 0, 0, C_ALL, 1, 32'h8, 1, (L == 1) ? 32'h4 : 32'h0);
        for (int k = 0; k < 4; k++)
            add(0, 1, 0, 0, 4'h0, 0, 32'h0, 0, 32'h0);
        run_vecs("redir");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
